latch_wr_arbiter: RTL and testbench
===================================

Name: latch_wr_arbiter

Overview:
- Sequences writes into an external bank of transparent D latches (dllD-style: d/en in, q/nq out) shared by 4 requesters.
- Arbitrates round-robin and registers the winner's data onto the shared latch D bus.
- Generates a clean latch-enable window (setup, open, hold) and verifies the latch Q after closing.
- Acks the winner with a pass/fail flag. Sits between requesting logic and the latch bank; all latch timing is owned here.

Parameters:
DATA_W, 8, width of latch data bus and of each requester's write word
OPEN_CYC, 2, clock cycles lat_en is held high per write (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  4  write request per requester, level, held until ack
wdata  input  4*DATA_W  flattened write words; requester i uses bits [i*DATA_W +: DATA_W]
lat_q  input  DATA_W  Q outputs of the latch bank, for verify
lat_d  output  DATA_W  registered data driven to latch D inputs
lat_en  output  1  latch enable, registered
ack  output  4  one-hot, one-cycle completion pulse to the granted requester
wr_err  output  1  one-cycle pulse coincident with ack when verify failed
gnt_id  output  2  index of the current/last granted requester
busy  output  1  high while a write is in progress

Behaviour:
- All outputs registered; every state change occurs on the rising edge of clk.
- Reset (rst=1 at an edge):
  - state=IDLE; lat_d=0, lat_en=0, ack=0, wr_err=0, gnt_id=0, busy=0.
  - Round-robin pointer=0, so req[0] has first priority.
  - Open-window counter=0.
- Reset mid-operation: the next edge forces all of the above. lat_en drops immediately. The latch keeps whatever it held, and no ack is issued for the aborted write.
- States: IDLE, SETUP, OPEN, HOLD.
- IDLE:
  - busy=0, lat_en=0, ack=0.
  - If req != 0, choose the first asserted bit scanning ptr, ptr+1, ... mod 4.
  - At that edge: lat_d <= winner's wdata slice, gnt_id <= winner, busy <= 1, state <= SETUP.
  - If req == 0, stay in IDLE; lat_d holds its last value.
- SETUP: exactly 1 cycle. lat_en=0 and lat_d stable. Next: OPEN, with counter loaded to OPEN_CYC-1.
- OPEN:
  - lat_en=1 for exactly OPEN_CYC consecutive cycles.
  - The counter decrements each cycle; when it reaches 0, go to HOLD.
- HOLD: exactly 1 cycle. lat_en=0 and lat_d still stable. Verify compare is taken in this cycle: mismatch = (lat_q != lat_d).
- Exit from HOLD (edge):
  - ack[gnt_id] <= 1 and wr_err <= mismatch, both for one cycle.
  - ptr <= gnt_id+1 mod 4.
  - state <= IDLE.
- Timing:
  - The ack cycle is the first IDLE cycle.
  - Arbitration may happen in that same cycle, but the just-acked requester has lowest priority.
  - A request still high in the ack cycle is treated as a new request.
- Latency from the grant edge to the ack pulse: OPEN_CYC+2 edges. Back-to-back writes take one transaction every OPEN_CYC+3 cycles.
- Once granted, the write always completes:
  - Deasserting req mid-write is ignored.
  - Changes on wdata after the grant edge are ignored.
- lat_d never changes while lat_en=1 or in SETUP/HOLD, which guarantees latch setup and hold.
- lat_en is never high outside OPEN, including during reset.
- Simultaneous requests are resolved only by the pointer. No requester can be starved: worst-case wait is 3 transactions.
- gnt_id holds its value through IDLE until the next grant.

Test Plan:
1. Reset, then req=4'b0001, wdata[7:0]=8'hA5, OPEN_CYC=2 -> grant edge, then SETUP, 2 cycles of lat_en=1 with lat_d=A5, HOLD, then ack=4'b0001 exactly 4 edges after grant. With the latch model wired, wr_err=0.
2. req=4'b1111 held continuously, each slice distinct (11,22,33,44) -> grant order 0,1,2,3,0. Each ack lines up with its own data on lat_d. Ack pulses are spaced 5 cycles apart.
3. Force lat_q=8'h00 while writing 8'h5A -> ack pulses with wr_err=1 in the same cycle. The next write with a correct lat_q gives wr_err=0.
4. Assert rst during OPEN -> lat_en=0, busy=0, ack=0, and gnt_id=0 after that edge. The following request from req[2] with req[0] also high is granted to req[0] (pointer reset).
5. Drop req and change wdata one cycle after grant -> the write still completes with the original data and ack still pulses.
6. OPEN_CYC=1 and OPEN_CYC=15 builds -> lat_en high for exactly 1 and 15 cycles. lat_d is stable from the grant edge through HOLD.

Source files
------------

// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter
// Round-robin write sequencer for a bank of transparent D latches shared by
// four requesters. The winner's word is registered onto the latch D bus, the
// latch enable is opened for a fixed window bracketed by one setup and one
// hold cycle, and the latch Q is compared against D before the requester is
// acknowledged with a pass/fail flag.
module latch_wr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int OPEN_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]     lat_q,
    output logic [DATA_W-1:0]     lat_d,
    output logic                  lat_en,
    output logic [3:0]            ack,
    output logic                  wr_err,
    output logic [1:0]            gnt_id,
    output logic                  busy
);

    // OPEN_CYC is limited to 1..15, so four bits always hold OPEN_CYC-1
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         ptr;
    logic [1:0]         ptr_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [DATA_W-1:0]  lat_d_nx;
    logic               lat_en_nx;
    logic [3:0]         ack_nx;
    logic               wr_err_nx;
    logic [1:0]         gnt_id_nx;
    logic               busy_nx;

    logic [1:0]         scan_idx;
    logic [1:0]         winner;
    logic               win_found;

    // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod 4
    always_comb begin
        scan_idx  = ptr;
        winner    = ptr;
        win_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!win_found && req[scan_idx]) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered one edge later
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        lat_d_nx  = lat_d;
        lat_en_nx = 1'b0;
        ack_nx    = 4'b0000;
        wr_err_nx = 1'b0;
        gnt_id_nx = gnt_id;
        busy_nx   = busy;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (win_found) begin
                    lat_d_nx  = wdata[winner*DATA_W +: DATA_W];
                    gnt_id_nx = winner;
                    busy_nx   = 1'b1;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                cnt_nx    = CNT_W'(OPEN_CYC - 1);
                lat_en_nx = 1'b1;
                state_nx  = OPEN;
            end
            OPEN: begin
                if (cnt == '0) begin
                    lat_en_nx = 1'b0;
                    state_nx  = HOLD;
                end else begin
                    cnt_nx    = cnt - 1'b1;
                    lat_en_nx = 1'b1;
                end
            end
            HOLD: begin
                ack_nx[gnt_id] = 1'b1;
                wr_err_nx      = (lat_q != lat_d);
                ptr_nx         = gnt_id + 2'd1;
                busy_nx        = 1'b0;
                state_nx       = IDLE;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; an aborted write
    // simply drops the enable and never acknowledges
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            cnt    <= '0;
            lat_d  <= '0;
            lat_en <= 1'b0;
            ack    <= 4'b0000;
            wr_err <= 1'b0;
            gnt_id <= 2'd0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
            lat_d  <= lat_d_nx;
            lat_en <= lat_en_nx;
            ack    <= ack_nx;
            wr_err <= wr_err_nx;
            gnt_id <= gnt_id_nx;
            busy   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb_latch_wr_arbiter
// Drives three copies of the arbiter (OPEN_CYC = 2, 1, 15) with shared
// stimulus. Each copy has its own transparent-latch model on lat_q and its
// own transaction-timeline reference model that predicts every output on
// every cycle from the grant time and the round-robin rule.
module tb_latch_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [4*DW-1:0]   wdata;

    logic [DW-1:0]     lat_q   [N];
    logic [DW-1:0]     lat_d   [N];
    logic              lat_en  [N];
    logic [3:0]        ack     [N];
    logic              wr_err  [N];
    logic [1:0]        gnt_id  [N];
    logic              busy    [N];
    logic              corrupt [N];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, one entry per instance
    bit                act_m   [N];
    int                k_m     [N];
    int                ptr_m   [N];
    int                gid_m   [N];
    logic [DW-1:0]     data_m  [N];
    logic [DW-1:0]     exp_d   [N];
    logic [3:0]        exp_ack [N];
    logic              exp_err [N];
    logic [1:0]        exp_gnt [N];

    always #5 clk = ~clk;

    latch_wr_arbiter #(.DATA_W(DW), .OPEN_CYC(2)) u_dut_oc2 (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lat_q(lat_q[0]),
        .lat_d(lat_d[0]), .lat_en(lat_en[0]), .ack(ack[0]), .wr_err(wr_err[0]),
        .gnt_id(gnt_id[0]), .busy(busy[0])
    );

    latch_wr_arbiter #(.DATA_W(DW), .OPEN_CYC(1)) u_dut_oc1 (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lat_q(lat_q[1]),
        .lat_d(lat_d[1]), .lat_en(lat_en[1]), .ack(ack[1]), .wr_err(wr_err[1]),
        .gnt_id(gnt_id[1]), .busy(busy[1])
    );

    latch_wr_arbiter #(.DATA_W(DW), .OPEN_CYC(15)) u_dut_oc15 (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lat_q(lat_q[2]),
        .lat_d(lat_d[2]), .lat_en(lat_en[2]), .ack(ack[2]), .wr_err(wr_err[2]),
        .gnt_id(gnt_id[2]), .busy(busy[2])
    );

    // Transparent latch per instance; corrupt forces the read-back to zero
    for (genvar g = 0; g < N; g++) begin : g_latch
        logic [DW-1:0] mem;
        always_latch begin
            if (lat_en[g]) mem <= lat_d[g];
        end
        assign lat_q[g] = corrupt[g] ? '0 : mem;
    end

    function automatic int oc_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic check_val(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s inst%0d: got %0h, expected %0h", name, inst, act, exp);
        end
    endtask

    // Advance the timeline model of instance i across the edge just taken
    task automatic model_update(input int i);
        int  w;
        int  c;
        bit  found;
        if (rst) begin
            act_m[i]   = 1'b0;
            k_m[i]     = 0;
            ptr_m[i]   = 0;
            exp_d[i]   = '0;
            exp_ack[i] = 4'b0000;
            exp_err[i] = 1'b0;
            exp_gnt[i] = 2'd0;
        end else begin
            exp_ack[i] = 4'b0000;
            exp_err[i] = 1'b0;
            if (act_m[i]) begin
                k_m[i]++;
                if (k_m[i] == oc_of(i) + 3) begin
                    exp_ack[i] = 4'b0001 << gid_m[i];
                    exp_err[i] = (lat_q[i] !== data_m[i]);
                    ptr_m[i]   = (gid_m[i] + 1) % 4;
                    act_m[i]   = 1'b0;
                end
            end else if (req != 4'b0000) begin
                found = 1'b0;
                w     = 0;
                for (int j = 0; j < 4; j++) begin
                    c = (ptr_m[i] + j) % 4;
                    if (!found && req[c]) begin
                        w     = c;
                        found = 1'b1;
                    end
                end
                act_m[i]   = 1'b1;
                k_m[i]     = 1;
                gid_m[i]   = w;
                data_m[i]  = wdata[w*DW +: DW];
                exp_d[i]   = data_m[i];
                exp_gnt[i] = 2'(w);
            end
        end
    endtask

    task automatic checkOutput(input int i);
        logic exp_en;
        exp_en = act_m[i] && (k_m[i] >= 2) && (k_m[i] <= oc_of(i) + 1);
        check_val("lat_d",  i, 32'(lat_d[i]),  32'(exp_d[i]));
        check_val("lat_en", i, 32'(lat_en[i]), 32'(exp_en));
        check_val("ack",    i, 32'(ack[i]),    32'(exp_ack[i]));
        check_val("wr_err", i, 32'(wr_err[i]), 32'(exp_err[i]));
        check_val("gnt_id", i, 32'(gnt_id[i]), 32'(exp_gnt[i]));
        check_val("busy",   i, 32'(busy[i]),   32'(act_m[i]));
    endtask

    // One clock: sample 1ns after the edge, update models, compare all copies
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            model_update(i);
            checkOutput(i);
        end
    endtask

    task automatic applyStimulus();
        rst   = ($urandom_range(0, 99) == 0);
        req   = 4'($urandom) & 4'($urandom);
        wdata = (4*DW)'($urandom);
        for (int i = 0; i < N; i++) begin
            if (!act_m[i] && $urandom_range(0, 7) == 0) corrupt[i] = ~corrupt[i];
        end
    endtask

    task automatic wait_ack0(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int t = 0; t < budget; t++) begin
            step();
            if (ack[0] != 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL %s: no ack within %0d cycles", name, budget);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        req  = 4'b0000;
        for (int t = 0; t < 60; t++) begin
            step();
            if (!act_m[0] && !act_m[1] && !act_m[2]) begin
                idle = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!idle) begin
            tests_failed++;
            $display("[TB] FAIL drain: still busy after 60 cycles");
        end
    endtask

    function automatic logic [1:0] rr_order(input int n);
        case (n)
            0:       return 2'd0;
            1:       return 2'd1;
            2:       return 2'd2;
            3:       return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] rr_data(input int n);
        case (n)
            0:       return 8'h11;
            1:       return 8'h22;
            2:       return 8'h33;
            3:       return 8'h44;
            default: return 8'h11;
        endcase
    endfunction

    initial begin
        int edges;
        int ack_at [N];
        int en_cnt [N];
        int nacks;
        int last;

        rst   = 1'b1;
        req   = 4'b0000;
        wdata = '0;
        for (int i = 0; i < N; i++) begin
            corrupt[i] = 1'b0;
            act_m[i]   = 1'b0;
            k_m[i]     = 0;
            ptr_m[i]   = 0;
            gid_m[i]   = 0;
            data_m[i]  = '0;
        end

        // Reset state
        @(negedge clk);
        step();
        step();
        check_val("reset_lat_en", 0, 32'(lat_en[0]), 32'd0);
        check_val("reset_busy",   0, 32'(busy[0]),   32'd0);
        check_val("reset_gnt_id", 0, 32'(gnt_id[0]), 32'd0);
        check_val("reset_lat_d",  0, 32'(lat_d[0]),  32'h00);
        rst = 1'b0;

        // Single write of A5 from requester 0: latency and window length
        wdata = 32'h000000A5;
        req   = 4'b0001;
        step();
        check_val("grant_busy", 0, 32'(busy[0]), 32'd1);
        for (int i = 0; i < N; i++) begin
            ack_at[i] = 0;
            en_cnt[i] = 0;
        end
        edges = 0;
        for (int t = 0; t < 25; t++) begin
            step();
            edges++;
            for (int i = 0; i < N; i++) begin
                if (ack_at[i] == 0 && lat_en[i]) en_cnt[i]++;
                if (ack_at[i] == 0 && ack[i] != 4'b0000) ack_at[i] = edges;
            end
            if (ack_at[0] == edges) begin
                check_val("t1_lat_d", 0, 32'(lat_d[0]),  32'hA5);
                check_val("t1_ack",   0, 32'(ack[0]),    32'b0001);
                check_val("t1_wr_err",0, 32'(wr_err[0]), 32'd0);
                req = 4'b0000;
            end
        end
        check_val("t1_latency", 0, 32'(ack_at[0]), 32'd4);
        check_val("t1_latency", 1, 32'(ack_at[1]), 32'd3);
        check_val("t1_latency", 2, 32'(ack_at[2]), 32'd17);
        check_val("t1_en_len",  0, 32'(en_cnt[0]), 32'd2);
        check_val("t1_en_len",  1, 32'(en_cnt[1]), 32'd1);
        check_val("t1_en_len",  2, 32'(en_cnt[2]), 32'd15);
        drain();

        // All four requesting continuously after a reset: order 0,1,2,3,0
        rst = 1'b1;
        step();
        rst   = 1'b0;
        wdata = 32'h44332211;
        req   = 4'b1111;
        nacks = 0;
        last  = 0;
        edges = 0;
        for (int t = 0; t < 60 && nacks < 5; t++) begin
            step();
            edges++;
            if (ack[0] != 4'b0000) begin
                check_val("rr_order", 0, 32'(gnt_id[0]), 32'(rr_order(nacks)));
                check_val("rr_data",  0, 32'(lat_d[0]),  32'(rr_data(nacks)));
                if (nacks > 0) check_val("rr_spacing", 0, 32'(edges - last), 32'd5);
                last = edges;
                nacks++;
            end
        end
        check_val("rr_count", 0, 32'(nacks), 32'd5);
        drain();

        // Verify failure with read-back forced low, then a clean write
        corrupt[0] = 1'b1;
        wdata      = 32'h00005A00;
        req        = 4'b0010;
        wait_ack0("t3_bad_ack", 20);
        check_val("t3_bad_err", 0, 32'(wr_err[0]), 32'd1);
        req = 4'b0000;
        drain();
        corrupt[0] = 1'b0;
        req        = 4'b0010;
        wait_ack0("t3_good_ack", 20);
        check_val("t3_good_err", 0, 32'(wr_err[0]), 32'd0);
        drain();

        // Reset in the middle of the open window, then pointer back to 0
        req = 4'b0010;
        for (int t = 0; t < 10 && !lat_en[0]; t++) step();
        check_val("t4_in_open", 0, 32'(lat_en[0]), 32'd1);
        rst = 1'b1;
        step();
        check_val("t4_lat_en", 0, 32'(lat_en[0]), 32'd0);
        check_val("t4_busy",   0, 32'(busy[0]),   32'd0);
        check_val("t4_ack",    0, 32'(ack[0]),    32'd0);
        check_val("t4_gnt_id", 0, 32'(gnt_id[0]), 32'd0);
        rst   = 1'b0;
        wdata = 32'h00CC0077;
        req   = 4'b0101;
        step();
        check_val("t4_regrant", 0, 32'(gnt_id[0]), 32'd0);
        check_val("t4_lat_d",   0, 32'(lat_d[0]),  32'h77);
        drain();

        // Request dropped and data changed right after the grant
        wdata = 32'hC3000000;
        req   = 4'b1000;
        step();
        req   = 4'b0000;
        wdata = 32'h3C000000;
        wait_ack0("t5_ack_wait", 10);
        check_val("t5_ack",   0, 32'(ack[0]),   32'b1000);
        check_val("t5_lat_d", 0, 32'(lat_d[0]), 32'hC3);
        drain();

        // Randomized traffic with occasional resets and read-back faults
        for (int t = 0; t < 1500; t++) begin
            applyStimulus();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
